// File: rtl/snn_sched_pkg.sv
// -----------------------------------------------------------------------------
// snn_sched_pkg
// Shared types and constants for the spike scheduler.
//   sched_state_t : scheduler FSM states (IDLE, RUN, DRAIN, TICK)
//   DEF_*         : default parameter values
//   win_width()   : width of the per-timestep window counter
// -----------------------------------------------------------------------------
package snn_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        TICK  = 2'd3
    } sched_state_t;

    localparam int DEF_NUM_SOURCES     = 4;
    localparam int DEF_TIMESTEP_CYCLES = 16;
    localparam int DEF_STEP_W          = 16;

    // Window counter only has to reach TIMESTEP_CYCLES-1.
    function automatic int win_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/snn_rr_arbiter.sv
// -----------------------------------------------------------------------------
// snn_rr_arbiter
// Combinational round-robin pick: first set bit of i_cand found when scanning
// upward from i_ptr, wrapping at NUM_SOURCES.
//   i_cand   [NUM_SOURCES] candidate request mask
//   i_ptr    [ADDR_W]      highest-priority index this cycle
//   o_winner [ADDR_W]      selected index (0 when nothing found)
//   o_found                at least one candidate was set
// -----------------------------------------------------------------------------
module snn_rr_arbiter #(
    parameter int NUM_SOURCES = 4,
    parameter int ADDR_W      = $clog2(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] i_cand,
    input  logic [ADDR_W-1:0]      i_ptr,
    output logic [ADDR_W-1:0]      o_winner,
    output logic                   o_found
);

    // One spare bit so ptr+offset cannot overflow before the wrap.
    logic [ADDR_W:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            w_idx = {1'b0, i_ptr} + (ADDR_W+1)'(k);
            if (w_idx >= (ADDR_W+1)'(NUM_SOURCES))
                w_idx = w_idx - (ADDR_W+1)'(NUM_SOURCES);
            if (!o_found && i_cand[w_idx[ADDR_W-1:0]]) begin
                o_found  = 1'b1;
                o_winner = w_idx[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/snn_spike_scheduler.sv
// -----------------------------------------------------------------------------
// snn_spike_scheduler
// Round-robin multiplexer of NUM_SOURCES spike requesters onto one valid/ready
// event channel, framed into fixed timesteps with a closing tick.
//   clk, rst       clock, asynchronous active-low reset
//   enable         keep running timesteps while high
//   req            level requests, held until grant or drop
//   grant          one-hot pulse, event accepted by the network
//   drop           per-source pulse, request discarded at timestep close
//   ev_valid/addr  registered event to the network; ev_ready accepts it
//   step_tick      one-cycle pulse at timestep close
//   step_count     completed timesteps (wraps)
//   overrun        sticky: some request was dropped since reset
// -----------------------------------------------------------------------------
module snn_spike_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_SOURCES     = DEF_NUM_SOURCES,   // >= 2
    parameter int TIMESTEP_CYCLES = DEF_TIMESTEP_CYCLES, // >= 3
    parameter int STEP_W          = DEF_STEP_W,
    parameter int ADDR_W          = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_SOURCES-1:0] req,
    output logic [NUM_SOURCES-1:0] grant,
    output logic [NUM_SOURCES-1:0] drop,
    output logic                   ev_valid,
    output logic [ADDR_W-1:0]      ev_addr,
    input  logic                   ev_ready,
    output logic                   step_tick,
    output logic [STEP_W-1:0]      step_count,
    output logic                   overrun
);

    localparam int                WIN_W    = win_width(TIMESTEP_CYCLES);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(TIMESTEP_CYCLES - 1);
    // Last window slot that may still load: leaves one cycle for the handshake
    // before the window closes.
    localparam logic [WIN_W-1:0]  WIN_LMAX = WIN_W'(TIMESTEP_CYCLES - 3);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_SOURCES - 1);

    sched_state_t          r_state;
    logic [WIN_W-1:0]      r_win;
    logic                  r_ev_valid;
    logic [ADDR_W-1:0]     r_ev_addr;
    logic [ADDR_W-1:0]     r_rr_ptr;
    logic [STEP_W-1:0]     r_step_count;
    logic                  r_overrun;

    logic                  w_hs;
    logic [NUM_SOURCES-1:0] w_grant;
    logic [NUM_SOURCES-1:0] w_drop;
    logic [NUM_SOURCES-1:0] w_cand;
    logic [ADDR_W-1:0]     w_winner;
    logic                  w_found;
    logic                  w_load;
    logic                  w_stuck;
    logic                  w_to_tick;
    logic [ADDR_W-1:0]     w_next_ptr;

    assign w_hs = r_ev_valid & ev_ready;

    always_comb begin
        w_grant = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            w_grant[i] = w_hs && (r_ev_addr == ADDR_W'(i));
    end

    // The source being accepted this cycle still shows req; exclude it.
    assign w_cand = req & ~w_grant;

    snn_rr_arbiter #(
        .NUM_SOURCES (NUM_SOURCES),
        .ADDR_W      (ADDR_W)
    ) u_arb (
        .i_cand   (w_cand),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    assign w_next_ptr = (w_winner == ADDR_MAX) ? '0 : w_winner + 1'b1;
    assign w_load     = (r_state == RUN) && (r_win <= WIN_LMAX) && (!r_ev_valid || ev_ready);
    // Event still outstanding after this cycle's handshake.
    assign w_stuck    = r_ev_valid && !ev_ready;
    assign w_to_tick  = ((r_state == RUN) && (r_win == WIN_LAST) && !w_stuck) ||
                        ((r_state == DRAIN) && w_hs);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_win        <= '0;
            r_ev_valid   <= 1'b0;
            r_ev_addr    <= '0;
            r_rr_ptr     <= '0;
            r_step_count <= '0;
            r_overrun    <= 1'b0;
        end else begin
            // Event register: load a new winner, or retire the accepted one.
            if (w_load) begin
                r_ev_valid <= w_found;
                if (w_found) begin
                    r_ev_addr <= w_winner;
                    r_rr_ptr  <= w_next_ptr;
                end
            end else if (w_hs) begin
                r_ev_valid <= 1'b0;
            end

            // step_count advances on entry to TICK so it reads updated there.
            if (w_to_tick)
                r_step_count <= r_step_count + 1'b1;

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= RUN;
                        r_win   <= '0;
                    end
                end
                RUN: begin
                    if (r_win == WIN_LAST)
                        r_state <= w_stuck ? DRAIN : TICK;
                    else
                        r_win <= r_win + 1'b1;
                end
                DRAIN: begin
                    if (w_hs)
                        r_state <= TICK;
                end
                TICK: begin
                    r_overrun <= r_overrun | (|w_drop);
                    r_win     <= '0;
                    r_state   <= enable ? RUN : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_drop     = (r_state == TICK) ? (req & ~w_grant) : '0;

    assign grant      = w_grant;
    assign drop       = w_drop;
    assign ev_valid   = r_ev_valid;
    assign ev_addr    = r_ev_addr;
    assign step_tick  = (r_state == TICK);
    assign step_count = r_step_count;
    // Show a fresh drop in the TICK cycle itself, then hold it.
    assign overrun    = r_overrun | (|w_drop);

endmodule

// File: tb/tb_snn_spike_scheduler.sv
module tb_snn_spike_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance (TIMESTEP_CYCLES=16)
    logic        en0, rdy0, evv0, tick0, ovr0;
    logic [3:0]  req0, grant0, drop0;
    logic [1:0]  eva0;
    logic [15:0] sc0;

    // Short-window instance (TIMESTEP_CYCLES=4)
    logic        en4, rdy4, evv4, tick4, ovr4;
    logic [3:0]  req4, grant4, drop4;
    logic [1:0]  eva4;
    logic [15:0] sc4;

    snn_spike_scheduler dut (
        .clk(clk), .rst(rst), .enable(en0), .req(req0), .grant(grant0), .drop(drop0),
        .ev_valid(evv0), .ev_addr(eva0), .ev_ready(rdy0), .step_tick(tick0),
        .step_count(sc0), .overrun(ovr0));

    snn_spike_scheduler #(.NUM_SOURCES(4), .TIMESTEP_CYCLES(4), .STEP_W(16)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .req(req4), .grant(grant4), .drop(drop4),
        .ev_valid(evv4), .ev_addr(eva4), .ev_ready(rdy4), .step_tick(tick4),
        .step_count(sc4), .overrun(ovr4));

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic [3:0] pend0, pend4;

    // Scoreboard: every accepted event of the default instance must match the
    // next expected source address.
    always @(negedge clk) begin
        if (rst && evv0 && rdy0) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got ev_addr=%0d grant=%b, want no event", eva0, grant0);
            end else begin
                int e;
                logic [3:0] eg;
                e  = exp_q.pop_front();
                eg = 4'(1 << e);
                if (eva0 !== 2'(e) || grant0 !== eg) begin
                    n_err++;
                    $display("FAIL sb_event: got addr=%0d grant=%b, want addr=%0d grant=%b", eva0, grant0, e, eg);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance one cycle from a negedge; requesters drop req after grant/drop.
    task automatic step();
        pend0 = grant0 | drop0;
        pend4 = grant4 | drop4;
        @(posedge clk); #1;
        req0 = req0 & ~pend0;
        req4 = req4 & ~pend4;
    endtask

    task automatic do_reset();
        rst = 1'b0; en0 = 0; en4 = 0; req0 = 0; req4 = 0; rdy0 = 0; rdy4 = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        en0 = 0; en4 = 0; req0 = 0; req4 = 0; rdy0 = 0; rdy4 = 0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({evv0, grant0, drop0, tick0, ovr0} !== 11'd0) begin n_err++;
            $display("FAIL reset_outs: got %b want 0", {evv0, grant0, drop0, tick0, ovr0}); end
        n_cmp++; if (sc0 !== 16'd0) begin n_err++; $display("FAIL reset_sc: got %0d want 0", sc0); end
        n_cmp++; if ({evv4, tick4, ovr4, sc4} !== 19'd0) begin n_err++;
            $display("FAIL reset_outs4: got %h want 0", {evv4, tick4, ovr4, sc4}); end
        @(posedge clk); #1 rst = 1'b1;
        req0 = 4'b0001;  // IDLE must not issue
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if ({evv0, tick0} !== 2'b00) begin n_err++;
                $display("FAIL idle_quiet: got valid/tick=%b want 00", {evv0, tick0}); end
            step();
        end
        req0 = 0;
    endtask

    task automatic test_single();
        en0 = 1; @(negedge clk); step();   // c=1 is win=0
        req0 = 4'b0100; rdy0 = 1; exp_q.push_back(2);
        for (int c = 1; c <= 20; c++) begin
            if (c == 17) en0 = 0;
            @(negedge clk);
            if (c == 2) begin
                n_cmp++; if ({evv0, eva0, grant0} !== {1'b1, 2'd2, 4'b0100}) begin n_err++;
                    $display("FAIL single_ev: got v=%b a=%0d g=%b want v=1 a=2 g=0100", evv0, eva0, grant0); end
            end
            n_cmp++; if (tick0 !== (c == 17)) begin n_err++;
                $display("FAIL single_tick c=%0d: got %b want %b", c, tick0, (c == 17)); end
            n_cmp++; if (drop0 !== 4'b0) begin n_err++; $display("FAIL single_drop: got %b want 0000", drop0); end
            if (c == 17) begin
                n_cmp++; if (sc0 !== 16'd1) begin n_err++; $display("FAIL single_sc: got %0d want 1", sc0); end
            end
            step();
        end
    endtask

    task automatic test_round_robin();
        logic ev; logic [1:0] ea;
        do_reset();
        en0 = 1; @(negedge clk); step();
        req0 = 4'b1111; rdy0 = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        for (int c = 1; c <= 34; c++) begin
            if (c == 6) begin req0 = 4'b0011; exp_q.push_back(0); exp_q.push_back(1); end
            if (c == 34) en0 = 0;
            @(negedge clk);
            ev = (c >= 2 && c <= 5) || c == 7 || c == 8;
            ea = (c <= 5) ? 2'(c - 2) : 2'(c - 7);
            n_cmp++; if (evv0 !== ev || (ev && eva0 !== ea)) begin n_err++;
                $display("FAIL rr_order c=%0d: got v=%b a=%0d want v=%b a=%0d", c, evv0, eva0, ev, ea); end
            n_cmp++; if (tick0 !== (c == 17 || c == 34)) begin n_err++;
                $display("FAIL rr_period c=%0d: got tick=%b", c, tick0); end
            if (c == 34) begin
                n_cmp++; if (sc0 !== 16'd2) begin n_err++; $display("FAIL rr_sc: got %0d want 2", sc0); end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        en0 = 1; @(negedge clk); step();
        req0 = 4'b0010; rdy0 = 0; exp_q.push_back(1);
        for (int c = 1; c <= 17; c++) begin
            if (c == 2) begin req0 = req0 | 4'b1000; exp_q.push_back(3); end
            if (c == 7) rdy0 = 1;
            if (c == 17) en0 = 0;
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                n_cmp++; if ({evv0, eva0, grant0} !== {1'b1, 2'd1, 4'b0000}) begin n_err++;
                    $display("FAIL bp_hold c=%0d: got v=%b a=%0d g=%b want v=1 a=1 g=0000", c, evv0, eva0, grant0); end
            end
            if (c == 7) begin
                n_cmp++; if (grant0 !== 4'b0010) begin n_err++; $display("FAIL bp_release: got %b want 0010", grant0); end
            end
            if (c == 8) begin
                n_cmp++; if ({evv0, eva0} !== {1'b1, 2'd3}) begin n_err++;
                    $display("FAIL bp_next: got v=%b a=%0d want v=1 a=3", evv0, eva0); end
            end
            if (c == 9) begin
                n_cmp++; if (evv0 !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", evv0); end
            end
            step();
        end
    endtask

    task automatic test_drain();
        en0 = 1; @(negedge clk); step();
        rdy0 = 0; req0 = 0;
        for (int c = 1; c <= 21; c++) begin
            if (c == 14) begin req0 = 4'b0001; exp_q.push_back(0); end  // win=13, last load slot
            if (c == 15) req0 = req0 | 4'b0010;                         // win=14, too late to load
            if (c == 20) rdy0 = 1;
            if (c == 21) en0 = 0;
            @(negedge clk);
            if (c >= 15 && c <= 19) begin
                n_cmp++; if ({evv0, eva0, grant0} !== {1'b1, 2'd0, 4'b0000}) begin n_err++;
                    $display("FAIL drain_hold c=%0d: got v=%b a=%0d g=%b", c, evv0, eva0, grant0); end
            end
            n_cmp++; if (tick0 !== (c == 21)) begin n_err++;
                $display("FAIL drain_tick c=%0d: got %b want %b", c, tick0, (c == 21)); end
            if (c == 21) begin
                n_cmp++; if (sc0 !== 16'd4) begin n_err++; $display("FAIL drain_sc: got %0d want 4", sc0); end
                n_cmp++; if ({drop0, ovr0} !== {4'b0010, 1'b1}) begin n_err++;
                    $display("FAIL drain_drop: got drop=%b ovr=%b want 0010 1", drop0, ovr0); end
            end
            step();
        end
    endtask

    task automatic test_overrun();
        logic [3:0] eg;
        en4 = 1; @(negedge clk); step();
        req4 = 4'b1111; rdy4 = 1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 10) en4 = 0;
            @(negedge clk);
            eg = (c == 2) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
            n_cmp++; if (grant4 !== eg) begin n_err++;
                $display("FAIL ovr_grant c=%0d: got %b want %b", c, grant4, eg); end
            n_cmp++; if (tick4 !== (c == 5 || c == 10)) begin n_err++;
                $display("FAIL ovr_tick c=%0d: got %b", c, tick4); end
            if (c == 4) begin
                n_cmp++; if (ovr4 !== 1'b0) begin n_err++; $display("FAIL ovr_early: got %b want 0", ovr4); end
            end
            if (c == 5) begin
                n_cmp++; if ({drop4, ovr4, sc4} !== {4'b1100, 1'b1, 16'd1}) begin n_err++;
                    $display("FAIL ovr_tick1: got drop=%b ovr=%b sc=%0d want 1100 1 1", drop4, ovr4, sc4); end
            end
            if (c == 10) begin
                n_cmp++; if ({drop4, ovr4, sc4} !== {4'b0000, 1'b1, 16'd2}) begin n_err++;
                    $display("FAIL ovr_sticky: got drop=%b ovr=%b sc=%0d want 0000 1 2", drop4, ovr4, sc4); end
            end
            step();
        end
    endtask

    task automatic test_enable_reset();
        en0 = 1; @(negedge clk); step();
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) en0 = 0;
            @(negedge clk);
            n_cmp++; if (tick0 !== (c == 17)) begin n_err++;
                $display("FAIL en_tick c=%0d: got %b want %b", c, tick0, (c == 17)); end
            step();
        end
        // Reset in the middle of a presented event
        en0 = 1; @(negedge clk); step();
        req0 = 4'b0001; rdy0 = 0; exp_q.push_back(0);
        @(negedge clk); step();
        @(negedge clk);
        n_cmp++; if (evv0 !== 1'b1) begin n_err++; $display("FAIL rst_pre: got valid=%b want 1", evv0); end
        rst = 1'b0;
        #1;
        n_cmp++; if ({evv0, grant0, drop0, tick0, ovr0} !== 11'd0) begin n_err++;
            $display("FAIL rst_async: got %b want 0", {evv0, grant0, drop0, tick0, ovr0}); end
        n_cmp++; if ({sc0, sc4, ovr4} !== 33'd0) begin n_err++;
            $display("FAIL rst_counters: got sc=%0d sc4=%0d ovr4=%b want 0", sc0, sc4, ovr4); end
        exp_q.delete();  // abandoned without a grant
        @(posedge clk); #1;
        rst = 1'b1; en0 = 0; req0 = 0;
    endtask

    initial begin
        en0 = 0; en4 = 0; req0 = 0; req4 = 0; rdy0 = 0; rdy4 = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_overrun();
        test_enable_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_err++;
            $display("FAIL sb_leftover: got %0d pending events want 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_spike_scheduler.md
Name: snn_spike_scheduler

Overview:
- Time-multiplexes spike events from NUM_SOURCES independent requesters onto the single spike-event input of the integrate-and-fire network.
- Uses round-robin arbitration and valid/ready flow control.
- Frames the traffic into fixed-length timesteps and emits a per-timestep tick that drives the network's integrate/leak step.
- Spikes still unserved when a timestep closes are dropped and reported.

Parameters:
- NUM_SOURCES, 4: number of spike requesters; must be ≥2.
- TIMESTEP_CYCLES, 16: length of the RUN window in clocks; must be ≥3.
- STEP_W, 16: width of the timestep counter.
- ADDR_W, $clog2(NUM_SOURCES): derived; width of the event address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  run timesteps while high.
- req  in  NUM_SOURCES  level spike request per source; held until grant or drop.
- grant  out  NUM_SOURCES  one-hot pulse: request accepted by the network.
- drop  out  NUM_SOURCES  pulse per source: request discarded at timestep close.
- ev_valid  out  1  event presented to the network.
- ev_addr  out  ADDR_W  source index of the presented event.
- ev_ready  in  1  network accepts the event.
- step_tick  out  1  one-cycle pulse at each timestep close.
- step_count  out  STEP_W  number of completed timesteps.
- overrun  out  1  sticky flag: at least one drop since reset.

Behaviour:
- Reset (rst=0, asynchronous) forces all outputs, step_count, overrun, rr_ptr and the window counter to 0, and the state to IDLE. Reset mid-event abandons the event without a grant.
- FSM states: IDLE, RUN, DRAIN, TICK.
- IDLE: no events are issued. When enable=1, move to RUN with window counter win=0.
- RUN: win increments every cycle. At win=TIMESTEP_CYCLES-1:
  - if no event is outstanding after this cycle's handshake, move to TICK;
  - otherwise move to DRAIN.
- DRAIN: no new loads. Stay until the outstanding event handshakes, then move to TICK.
- TICK (1 cycle):
  - step_tick=1 and step_count increments, wrapping modulo 2^STEP_W.
  - drop = req & ~grant; overrun is set if drop≠0.
  - Next state is RUN (win=0) if enable=1, otherwise IDLE.
- enable=0 during RUN or DRAIN does not abort: the current timestep completes and the block enters IDLE after TICK.
- Event channel: ev_valid and ev_addr are registered. Once ev_valid is asserted, ev_valid and ev_addr stay stable until ev_valid&ev_ready.
- Load condition: at a clock edge in RUN with win≤TIMESTEP_CYCLES-3, the next event is loaded when (!ev_valid or ev_ready). Candidates are req minus the source being handshaked this cycle. ev_valid deasserts when nothing is loaded.
- Latency is 1 cycle from req to ev_valid. Sustained throughput is 1 event/cycle when ev_ready=1.
- grant is combinational: grant[i] = ev_valid & ev_ready & (ev_addr==i). The requester deasserts req at the following edge.
- Round-robin:
  - search starts at rr_ptr and wraps;
  - on each load, rr_ptr becomes winner+1 mod NUM_SOURCES;
  - rr_ptr persists across timesteps.
- grant and drop are never both high for the same source in the same cycle.
- Step period is TIMESTEP_CYCLES+1 cycles without backpressure, plus 1 cycle per DRAIN cycle.

Decomposition:
- Package snn_sched_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, TICK);
  - the default constants;
  - a function computing the window counter width from TIMESTEP_CYCLES.
- Sub-module snn_rr_arbiter: combinational round-robin priority pick.
  - Inputs: candidate mask, rr_ptr.
  - Outputs: winner index, found flag.
- The FSM, event register, counters and flags live in the top.

Test Plan:
- Single event: defaults, enable=1, ev_ready=1, req[2] raised at win=0 → ev_valid=1 and ev_addr=2 at the next cycle; grant[2] pulses in that cycle; no drop; first step_tick 17 cycles after entering RUN; step_count=1.
- Round-robin order: req=4'b1111 held (each source drops req on its grant), rr_ptr=0 → events 0,1,2,3 in consecutive cycles. Then req=4'b0011 → order 0,1 (rr_ptr=0 after wrap).
- Backpressure: ev_ready=0 for 5 cycles with ev_addr=1 presented → ev_valid and ev_addr stable, no grant. ev_ready=1 → grant[1] the same cycle, next event the following cycle.
- Overrun: TIMESTEP_CYCLES=4, req=4'b1111 at win=0 → only 2 events issued (loads at win 0,1). TICK shows drop=4'b1100, overrun=1 and sticky, step_count=1.
- DRAIN: ev_ready held 0 past window end → DRAIN entered; step_tick delayed until ev_ready=1, then TICK the next cycle.
- Reset and enable: enable dropped mid-window → current step finishes, one step_tick, then IDLE with no further ticks. rst asserted mid-event → all outputs 0 immediately; step_count=0, overrun=0.
